// File: rtl/guideir_arith_pkg.sv
// Shared arithmetic helpers for the shift-multiply datapath:
// power-of-two check, shift derivation and signed saturation limits.
package guideir_arith_pkg;

   function automatic bit f_is_pow2(input int v);
      return (v >= 1) && ((v & (v - 1)) == 0);
   endfunction

   function automatic int f_shift(input int mult);
      return $clog2(mult);
   endfunction

   function automatic longint f_smax(input int dw);
      return (longint'(1) <<< (dw - 1)) - longint'(1);
   endfunction

   function automatic longint f_smin(input int dw);
      return -(longint'(1) <<< (dw - 1));
   endfunction

endpackage

// File: rtl/vr_pipe_stage.sv
// One valid/ready register slice; loads whenever it is empty or its
// content is leaving, so bubbles collapse and throughput stays at 1/clk.
module vr_pipe_stage #(
   parameter int W = 33
) (
   input  logic         i_Sys_clk,
   input  logic         i_Rst,
   input  logic         i_Valid,
   output logic         o_Ready,
   input  logic [W-1:0] i_Data,
   output logic         o_Valid,
   input  logic         i_Ready,
   output logic [W-1:0] o_Data
);

   assign o_Ready = ~o_Valid | i_Ready;

   always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Valid <= 1'b0;
         o_Data  <= '0;
      end else if (o_Ready) begin
         o_Valid <= i_Valid;
         if (i_Valid) o_Data <= i_Data;
      end
   end

endmodule

// File: rtl/multiplier_shift.sv
// Signed multiply by MULT (a power of two) as an arithmetic left shift,
// saturated to DW bits, with a sticky count of clamped samples delivered.
module multiplier_shift
   import guideir_arith_pkg::*;
#(
   parameter int DW     = 32,
   parameter int MULT   = 1024,
   parameter int SCNT_W = 16
) (
   input  logic                 i_Sys_clk,
   input  logic                 i_Rst,
   input  logic                 i_Valid,
   output logic                 o_Ready,
   input  logic signed [DW-1:0] i_Numer,
   output logic                 o_Valid,
   input  logic                 i_Ready,
   output logic signed [DW-1:0] o_Product,
   output logic                 o_Sat,
   input  logic                 i_Clr_cnt,
   output logic [SCNT_W-1:0]    o_Sat_cnt
);

   localparam int SHIFT = f_shift(MULT);
   localparam int XW    = DW + SHIFT;
   localparam logic signed [DW-1:0] SMAX = DW'(f_smax(DW));
   localparam logic signed [DW-1:0] SMIN = DW'(f_smin(DW));
   localparam logic [SCNT_W-1:0]    CNT_MAX = '1;

   generate
      if (!f_is_pow2(MULT)) begin : g_bad_mult
         $error("multiplier_shift: MULT must be a power of two >= 1");
      end
   endgenerate

   logic signed [XW-1:0] s1_in;
   logic        [XW-1:0] s1_q;
   logic                 s1_v;
   logic                 s2_rdy;
   logic                 fits;
   logic                 sat_flag;
   logic        [DW-1:0] sat_val;
   logic        [DW:0]   s2_q;

   assign s1_in = XW'(i_Numer) <<< SHIFT;

   vr_pipe_stage #(.W(XW)) u_s1 (
      .i_Sys_clk (i_Sys_clk),
      .i_Rst     (i_Rst),
      .i_Valid   (i_Valid),
      .o_Ready   (o_Ready),
      .i_Data    (s1_in),
      .o_Valid   (s1_v),
      .i_Ready   (s2_rdy),
      .o_Data    (s1_q)
   );

   // Value fits in DW bits iff every bit above the DW-1 sign position matches it.
   assign fits = (s1_q[XW-1:DW-1] == {(SHIFT + 1){s1_q[XW-1]}});

   always_comb begin
      sat_flag = ~fits;
      sat_val  = s1_q[DW-1:0];
      if (!fits) sat_val = s1_q[XW-1] ? SMIN : SMAX;
   end

   vr_pipe_stage #(.W(DW + 1)) u_s2 (
      .i_Sys_clk (i_Sys_clk),
      .i_Rst     (i_Rst),
      .i_Valid   (s1_v),
      .o_Ready   (s2_rdy),
      .i_Data    ({sat_flag, sat_val}),
      .o_Valid   (o_Valid),
      .i_Ready   (i_Ready),
      .o_Data    (s2_q)
   );

   assign o_Sat     = s2_q[DW];
   assign o_Product = s2_q[DW-1:0];

   always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Sat_cnt <= '0;
      end else if (i_Clr_cnt) begin
         o_Sat_cnt <= '0;
      end else if (o_Valid && i_Ready && o_Sat && (o_Sat_cnt != CNT_MAX)) begin
         o_Sat_cnt <= o_Sat_cnt + SCNT_W'(1);
      end
   end

endmodule

// File: tb/tb_multiplier_shift.sv
// Directed bench: scaling, saturation, backpressure, counter and reset
// behaviour at DW=16/MULT=1024, plus a MULT=1 pass-through instance.
module tb_multiplier_shift;

   logic               clk = 1'b0;
   logic               rst;
   logic               v, rdy, clr;
   logic signed [15:0] numer;
   logic               o_rdy, o_v, o_sat;
   logic signed [15:0] prod;
   logic [3:0]         cnt;

   logic               p_v, p_rdy, p_clr;
   logic signed [15:0] p_numer;
   logic               p_o_rdy, p_o_v, p_o_sat;
   logic signed [15:0] p_prod;
   logic [3:0]         p_cnt;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   multiplier_shift #(.DW(16), .MULT(1024), .SCNT_W(4)) dut (
      .i_Sys_clk (clk),   .i_Rst     (rst),
      .i_Valid   (v),     .o_Ready   (o_rdy),
      .i_Numer   (numer), .o_Valid   (o_v),
      .i_Ready   (rdy),   .o_Product (prod),
      .o_Sat     (o_sat), .i_Clr_cnt (clr),
      .o_Sat_cnt (cnt)
   );

   multiplier_shift #(.DW(16), .MULT(1), .SCNT_W(4)) dut_p (
      .i_Sys_clk (clk),     .i_Rst     (rst),
      .i_Valid   (p_v),     .o_Ready   (p_o_rdy),
      .i_Numer   (p_numer), .o_Valid   (p_o_v),
      .i_Ready   (p_rdy),   .o_Product (p_prod),
      .o_Sat     (p_o_sat), .i_Clr_cnt (p_clr),
      .o_Sat_cnt (p_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   initial begin
      int  in_i, out_i, stall;
      bit  seen, acc;

      rst = 1'b1; v = 1'b0; rdy = 1'b1; clr = 1'b0; numer = '0;
      p_v = 1'b0; p_rdy = 1'b1; p_clr = 1'b0; p_numer = '0;
      #2;
      chk("rst_valid", longint'(o_v), 0);
      chk("rst_prod",  longint'(prod), 0);
      chk("rst_sat",   longint'(o_sat), 0);
      chk("rst_cnt",   longint'(cnt), 0);
      #10 rst = 1'b0;
      tick();
      chk("idle_ready", longint'(o_rdy), 1);

      // Basic scaling, back-to-back
      v = 1'b1; numer = 16'sd5;
      tick();
      chk("lat_not_yet", longint'(o_v), 0);
      numer = -16'sd3;
      tick();
      chk("basic0_v", longint'(o_v), 1);
      chk("basic0_p", longint'(prod), 5120);
      chk("basic0_s", longint'(o_sat), 0);
      numer = 16'sd0;
      tick();
      chk("basic1_p", longint'(prod), -3072);
      chk("basic1_s", longint'(o_sat), 0);
      v = 1'b0;
      tick();
      chk("basic2_v", longint'(o_v), 1);
      chk("basic2_p", longint'(prod), 0);
      tick();
      chk("basic_drain", longint'(o_v), 0);

      // Saturation limits
      v = 1'b1; numer = 16'sd32;
      tick();
      numer = -16'sd32;
      tick();
      chk("sat0_p", longint'(prod), 32767);
      chk("sat0_s", longint'(o_sat), 1);
      numer = -16'sd33;
      tick();
      chk("sat1_p", longint'(prod), -32768);
      chk("sat1_s", longint'(o_sat), 0);
      numer = 16'sd31;
      tick();
      chk("sat2_p", longint'(prod), -32768);
      chk("sat2_s", longint'(o_sat), 1);
      v = 1'b0;
      tick();
      chk("sat3_p", longint'(prod), 31744);
      chk("sat3_s", longint'(o_sat), 0);
      chk("sat_cnt", longint'(cnt), 2);
      tick();

      // Backpressure: stream 1..6, hold i_Ready low 4 cycles after first output
      seen = 1'b0; stall = 0; in_i = 1; out_i = 1;
      for (int c = 0; c < 40 && out_i <= 6; c++) begin
         if (o_v && !seen) begin
            seen  = 1'b1;
            stall = 4;
         end
         rdy   = (stall == 0);
         v     = (in_i <= 6);
         numer = 16'(in_i);
         #1;
         if (stall > 0) begin
            chk("bp_ready_low", longint'(o_rdy), 0);
            chk("bp_hold", longint'(prod), longint'(out_i * 1024));
         end else if (o_v) begin
            chk("bp_order", longint'(prod), longint'(out_i * 1024));
            out_i++;
         end
         acc = v && o_rdy;
         tick();
         if (acc) in_i++;
         if (stall > 0) stall--;
      end
      chk("bp_all_out", longint'(out_i), 7);
      v = 1'b0; rdy = 1'b1;
      tick();
      chk("bp_no_dup", longint'(o_v), 0);

      // Counter saturates at all-ones
      v = 1'b1; numer = 16'sd100;
      for (int i = 0; i < 20; i++) tick();
      v = 1'b0;
      tick(); tick(); tick();
      chk("cnt_stick", longint'(cnt), 15);

      // Clear collides with a saturating output transfer
      v = 1'b1; numer = 16'sd100;
      tick();
      v = 1'b0;
      tick();
      chk("clr_sat_out", longint'(o_sat), 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_prio", longint'(cnt), 0);
      v = 1'b1; numer = -16'sd100;
      tick();
      v = 1'b0;
      tick(); tick();
      chk("cnt_after_clr", longint'(cnt), 1);

      // Async reset with both stages full
      rdy = 1'b0; v = 1'b1; numer = 16'sd7;
      tick();
      numer = 16'sd8;
      tick();
      v = 1'b0;
      chk("full_valid", longint'(o_v), 1);
      chk("full_ready", longint'(o_rdy), 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", longint'(o_v), 0);
      chk("arst_prod",  longint'(prod), 0);
      chk("arst_cnt",   longint'(cnt), 0);
      #1 rst = 1'b0;
      rdy = 1'b1;
      tick();
      chk("post_rst_idle", longint'(o_v), 0);
      v = 1'b1; numer = 16'sd3;
      tick();
      v = 1'b0;
      chk("post_rst_lat", longint'(o_v), 0);
      tick();
      chk("post_rst_v", longint'(o_v), 1);
      chk("post_rst_p", longint'(prod), 3072);
      tick();
      chk("post_rst_stale", longint'(o_v), 0);

      // MULT=1 pass-through
      p_v = 1'b1; p_numer = -16'sd32768;
      tick();
      chk("pt_lat", longint'(p_o_v), 0);
      p_numer = 16'sd32767;
      tick();
      p_v = 1'b0;
      chk("pt0_p", longint'(p_prod), -32768);
      chk("pt0_s", longint'(p_o_sat), 0);
      tick();
      chk("pt1_p", longint'(p_prod), 32767);
      chk("pt1_s", longint'(p_o_sat), 0);
      tick();
      chk("pt_cnt", longint'(p_cnt), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
